// File: rtl/weighted_priority_arbiter.sv
// Weighted round-robin arbiter: per-channel FIFOs, urgent preemption, registered valid/ack output.
// Optional per-channel grant counters are enabled with the macro ARBITER_GRANT_STATS_EN.
module weighted_priority_arbiter #(
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUEST                  = 4,
    parameter int NUM_REQUEST_LOG2             = $clog2(NUM_REQUEST),
    parameter int INPUT_QUEUE_SIZE             = 4,
    parameter int WEIGHT_WIDTH                 = 4,
    parameter int STARVATION_LIMIT             = 16,
    parameter int STAT_COUNTER_WIDTH           = 32
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_critical_flatted_in,
    output logic [NUM_REQUEST-1:0]                              issue_ack_out,
    input  logic [WEIGHT_WIDTH*NUM_REQUEST-1:0]                 weight_flatted_in,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
    output logic [NUM_REQUEST_LOG2-1:0]                         request_index_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in
`ifdef ARBITER_GRANT_STATS_EN
    ,
    output logic [STAT_COUNTER_WIDTH*NUM_REQUEST-1:0]           grant_count_flatted_out
`endif
);

    localparam int W  = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int N  = NUM_REQUEST;
    localparam int IW = NUM_REQUEST_LOG2;
    localparam int PW = $clog2(INPUT_QUEUE_SIZE);
    localparam int AW = $clog2(STARVATION_LIMIT + 1);
    localparam int WW = WEIGHT_WIDTH;

    localparam logic [AW-1:0] AGE_LIMIT   = AW'(STARVATION_LIMIT);
    localparam logic [PW:0]   QUEUE_DEPTH = (PW + 1)'(INPUT_QUEUE_SIZE);

    if (NUM_REQUEST < 2) begin : g_chk_num_request
        $error("NUM_REQUEST must be at least 2");
    end
    if (NUM_REQUEST_LOG2 < $clog2(NUM_REQUEST)) begin : g_chk_index_width
        $error("NUM_REQUEST_LOG2 too small for NUM_REQUEST");
    end
    if (INPUT_QUEUE_SIZE < 2 || (INPUT_QUEUE_SIZE & (INPUT_QUEUE_SIZE - 1)) != 0) begin : g_chk_queue
        $error("INPUT_QUEUE_SIZE must be a power of two and at least 2");
    end
    if (STARVATION_LIMIT < 1) begin : g_chk_starvation
        $error("STARVATION_LIMIT must be at least 1");
    end
    if (WEIGHT_WIDTH < 1 || STAT_COUNTER_WIDTH < 1) begin : g_chk_widths
        $error("WEIGHT_WIDTH and STAT_COUNTER_WIDTH must be at least 1");
    end

    // Channel index reached by stepping 'offset' places past 'base', wrapping.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] base, input int offset);
        int sum;
        sum = (int'(base) + offset) % N;
        return IW'(sum);
    endfunction

    // Remaining re-grants after the first grant of a burst; weight 0 behaves as 1.
    function automatic logic [WW-1:0] burst_credit(input logic [WW-1:0] weight);
        return (weight == '0) ? '0 : weight - 1'b1;
    endfunction

    logic [W-1:0]  payload_mem_q [N][INPUT_QUEUE_SIZE];
    logic          crit_mem_q    [N][INPUT_QUEUE_SIZE];

    logic [PW:0]   wr_ptr_q [N];
    logic [PW:0]   wr_ptr_d [N];
    logic [PW:0]   rd_ptr_q [N];
    logic [PW:0]   rd_ptr_d [N];
    logic [AW-1:0] age_q    [N];
    logic [AW-1:0] age_d    [N];

    logic [WW-1:0] credit_q, credit_d;
    logic [IW-1:0] last_grant_q, last_grant_d;
    logic [W-1:0]  req_out_q, req_out_d;
    logic [IW-1:0] req_idx_q, req_idx_d;
    logic          req_vld_q, req_vld_d;

    logic [N-1:0]  push, pop, empty, full, eligible, urgent, head_crit;
    logic [PW:0]   occupancy    [N];
    logic [W-1:0]  head_payload [N];
    logic [WW-1:0] weight_ch    [N];

    logic          load, grant_vld, new_burst;
    logic          urg_found, elig_found;
    logic [IW-1:0] grant_idx, urg_idx, elig_idx;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            occupancy[i]     = wr_ptr_q[i] - rd_ptr_q[i];
            empty[i]         = (occupancy[i] == '0);
            full[i]          = (occupancy[i] == QUEUE_DEPTH);
            eligible[i]      = ~empty[i];
            head_payload[i]  = payload_mem_q[i][rd_ptr_q[i][PW-1:0]];
            head_crit[i]     = crit_mem_q[i][rd_ptr_q[i][PW-1:0]];
            urgent[i]        = eligible[i] & (head_crit[i] | full[i] | (age_q[i] >= AGE_LIMIT));
            weight_ch[i]     = weight_flatted_in[i*WW +: WW];
            issue_ack_out[i] = ~full[i] & ~reset_in;
            push[i]          = request_valid_flatted_in[i] & issue_ack_out[i];
        end
    end

    // Search both the urgent and the eligible sets in rotation order starting after last_grant.
    always_comb begin
        urg_found  = 1'b0;
        urg_idx    = '0;
        elig_found = 1'b0;
        elig_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!urg_found && urgent[rr_pick(last_grant_q, k)]) begin
                urg_found = 1'b1;
                urg_idx   = rr_pick(last_grant_q, k);
            end
            if (!elig_found && eligible[rr_pick(last_grant_q, k)]) begin
                elig_found = 1'b1;
                elig_idx   = rr_pick(last_grant_q, k);
            end
        end

        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        new_burst = 1'b0;
        if (urg_found) begin
            grant_vld = 1'b1;
            grant_idx = urg_idx;
            new_burst = 1'b1;
        end else if (eligible[last_grant_q] && credit_q != '0) begin
            grant_vld = 1'b1;
        end else if (elig_found) begin
            grant_vld = 1'b1;
            grant_idx = elig_idx;
            new_burst = 1'b1;
        end
    end

    always_comb begin
        load         = ~req_vld_q | issue_ack_in;
        credit_d     = credit_q;
        last_grant_d = last_grant_q;
        req_out_d    = req_out_q;
        req_idx_d    = req_idx_q;
        req_vld_d    = req_vld_q;
        pop          = '0;
        if (load) begin
            if (grant_vld) begin
                req_out_d    = head_payload[grant_idx];
                req_idx_d    = grant_idx;
                req_vld_d    = 1'b1;
                last_grant_d = grant_idx;
                credit_d     = new_burst ? burst_credit(weight_ch[grant_idx]) : credit_q - 1'b1;
                for (int i = 0; i < N; i++) begin
                    pop[i] = (grant_idx == IW'(i));
                end
            end else begin
                req_out_d = '0;
                req_vld_d = 1'b0;
            end
        end
    end

    // Age counts every cycle a queued head waits, stalls included, and clears on grant or empty.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i] + {{PW{1'b0}}, push[i]};
            rd_ptr_d[i] = rd_ptr_q[i] + {{PW{1'b0}}, pop[i]};
            if (empty[i] || pop[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] < AGE_LIMIT) begin
                age_d[i] = age_q[i] + 1'b1;
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                payload_mem_q[i][wr_ptr_q[i][PW-1:0]] <= request_flatted_in[i*W +: W];
                crit_mem_q[i][wr_ptr_q[i][PW-1:0]]    <= request_critical_flatted_in[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                age_q[i]    <= '0;
            end
            credit_q     <= '0;
            last_grant_q <= IW'(N - 1);
            req_out_q    <= '0;
            req_idx_q    <= '0;
            req_vld_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            age_q        <= age_d;
            credit_q     <= credit_d;
            last_grant_q <= last_grant_d;
            req_out_q    <= req_out_d;
            req_idx_q    <= req_idx_d;
            req_vld_q    <= req_vld_d;
        end
    end

    assign request_out       = req_out_q;
    assign request_index_out = req_idx_q;
    assign request_valid_out = req_vld_q;

`ifdef ARBITER_GRANT_STATS_EN
    logic [STAT_COUNTER_WIDTH-1:0] grant_cnt_q [N];
    logic [STAT_COUNTER_WIDTH-1:0] grant_cnt_d [N];

    // Counts completed handshakes per source channel, saturating at all-ones.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (req_vld_q && issue_ack_in && req_idx_q == IW'(i) && grant_cnt_q[i] != '1) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
            end
            grant_count_flatted_out[i*STAT_COUNTER_WIDTH +: STAT_COUNTER_WIDTH] = grant_cnt_q[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < N; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_weighted_priority_arbiter.sv
// Scoreboard bench for weighted_priority_arbiter: per-channel payload queues plus expected grant order.
module tb_weighted_priority_arbiter;

    logic         clk = 1'b0;
    logic         reset_in;
    logic [255:0] req_data;
    logic [3:0]   req_vld;
    logic [3:0]   req_crit;
    logic [3:0]   ack_out;
    logic [15:0]  weights;
    logic [63:0]  rout;
    logic [1:0]   ridx;
    logic         rvld;
    logic         ack_in;

    int           checks = 0;
    int           errors = 0;
    logic [63:0]  exp_q [4][$];
    int           exp_idx [$];
    logic [63:0]  seq_tag = 64'h0;
    logic [63:0]  exp_val;

    always #5 clk = ~clk;

    weighted_priority_arbiter dut (
        .clk_in                     (clk),
        .reset_in                   (reset_in),
        .request_flatted_in         (req_data),
        .request_valid_flatted_in   (req_vld),
        .request_critical_flatted_in(req_crit),
        .issue_ack_out              (ack_out),
        .weight_flatted_in          (weights),
        .request_out                (rout),
        .request_index_out          (ridx),
        .request_valid_out          (rvld),
        .issue_ack_in               (ack_in)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_vld  = '0;
        req_crit = '0;
    endtask

    task automatic push(input int ch, input logic crit);
        seq_tag = seq_tag + 1;
        req_data[ch*64 +: 64] = {8'hC0 + 8'(ch), 24'h0, seq_tag[31:0]};
        req_vld[ch]  = 1'b1;
        req_crit[ch] = crit;
        exp_q[ch].push_back({8'hC0 + 8'(ch), 24'h0, seq_tag[31:0]});
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        exp_idx.delete();
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        ack_in   = 1'b0;
        req_vld  = '0;
        req_crit = '0;
        tick();
        tick();
        reset_in = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        ack_in   = 1'b0;
        weights  = 16'h1111;
        tick();
        tick();
        checks++;
        if (rvld !== 1'b0 || rout !== 64'h0 || ridx !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b out=%h idx=%0d, required 0/0/0", rvld, rout, ridx);
        end
        checks++;
        if (ack_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_ack: ack=%b, required 0000 during reset", ack_out);
        end
        reset_in = 1'b0;
        #1;
        checks++;
        if (ack_out !== 4'hF) begin
            errors++;
            $display("FAIL reset_release_ack: ack=%b, required 1111", ack_out);
        end
        clear_model();
        tick();
    endtask

    task automatic test_single_push();
        do_reset();
        weights = 16'h1111;
        push(2, 1'b0);
        req_data[2*64 +: 64] = 64'hA5;
        void'(exp_q[2].pop_back());
        exp_q[2].push_back(64'hA5);
        tick();
        checks++;
        if (rvld !== 1'b0) begin
            errors++;
            $display("FAIL single_latency1: valid=%b one cycle after push, required 0", rvld);
        end
        tick();
        checks++;
        if (rvld !== 1'b1 || ridx !== 2'd2) begin
            errors++;
            $display("FAIL single_grant: valid=%b idx=%0d, required 1/2", rvld, ridx);
        end
        exp_val = exp_q[2].pop_front();
        checks++;
        if (rout !== exp_val) begin
            errors++;
            $display("FAIL single_payload: out=%h, required %h", rout, exp_val);
        end
        ack_in = 1'b1;
        tick();
        checks++;
        if (rvld !== 1'b0 || rout !== 64'h0) begin
            errors++;
            $display("FAIL single_drain: valid=%b out=%h, required 0/0 (queue empty)", rvld, rout);
        end
        ack_in = 1'b0;
    endtask

    task automatic test_weighted_rr();
        do_reset();
        weights = 16'h1131;
        for (int ch = 0; ch < 4; ch++) push(ch, 1'b0);
        tick();
        for (int ch = 0; ch < 4; ch++) push(ch, 1'b0);
        tick();
        push(0, 1'b0);
        tick();
        ack_in  = 1'b1;
        exp_idx = '{0, 1, 1, 1, 2, 3, 0, 1, 1, 1, 2, 3};
        for (int k = 0; k < 12; k++) begin
            int e;
            e = exp_idx.pop_front();
            checks++;
            if (rvld !== 1'b1 || int'(ridx) != e) begin
                errors++;
                $display("FAIL wrr_index[%0d]: valid=%b idx=%0d, required 1/%0d", k, rvld, ridx, e);
            end
            if (rvld === 1'b1) begin
                checks++;
                if (exp_q[ridx].size() == 0) begin
                    errors++;
                    $display("FAIL wrr_payload[%0d]: out=%h from idx %0d, required nothing queued", k, rout, ridx);
                end else begin
                    exp_val = exp_q[ridx].pop_front();
                    if (rout !== exp_val) begin
                        errors++;
                        $display("FAIL wrr_payload[%0d]: out=%h, required %h", k, rout, exp_val);
                    end
                end
                if (k > 0) push(int'(ridx), 1'b0);
            end
            tick();
        end
        ack_in = 1'b0;
    endtask

    task automatic test_critical_preempt();
        do_reset();
        weights = 16'h1131;
        push(1, 1'b0);
        tick();
        push(1, 1'b0);
        tick();
        push(1, 1'b0);
        tick();
        push(3, 1'b1);
        push(0, 1'b0);
        tick();
        ack_in  = 1'b1;
        exp_idx = '{1, 3, 0, 1, 1};
        for (int k = 0; k < 5; k++) begin
            int e;
            e = exp_idx.pop_front();
            checks++;
            if (rvld !== 1'b1 || int'(ridx) != e) begin
                errors++;
                $display("FAIL crit_index[%0d]: valid=%b idx=%0d, required 1/%0d", k, rvld, ridx, e);
            end else if (exp_q[ridx].size() == 0) begin
                errors++;
                $display("FAIL crit_payload[%0d]: out=%h, required nothing queued on %0d", k, rout, ridx);
            end else begin
                exp_val = exp_q[ridx].pop_front();
                if (rout !== exp_val) begin
                    errors++;
                    $display("FAIL crit_payload[%0d]: out=%h, required %h", k, rout, exp_val);
                end
            end
            tick();
        end
        checks++;
        if (rvld !== 1'b0) begin
            errors++;
            $display("FAIL crit_idle: valid=%b after all entries, required 0", rvld);
        end
        ack_in = 1'b0;
    endtask

    task automatic test_stall_starvation();
        logic [63:0] held;
        do_reset();
        weights = 16'h1113;
        push(0, 1'b0);
        tick();
        push(0, 1'b0);
        push(2, 1'b0);
        tick();
        held = exp_q[0][0];
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (rvld !== 1'b1 || ridx !== 2'd0 || rout !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b idx=%0d out=%h, required 1/0/%h", c, rvld, ridx, rout, held);
            end
        end
        ack_in  = 1'b1;
        exp_idx = '{0, 2, 0};
        for (int k = 0; k < 3; k++) begin
            int e;
            e = exp_idx.pop_front();
            checks++;
            if (rvld !== 1'b1 || int'(ridx) != e) begin
                errors++;
                $display("FAIL starve_index[%0d]: valid=%b idx=%0d, required 1/%0d", k, rvld, ridx, e);
            end else if (exp_q[ridx].size() == 0) begin
                errors++;
                $display("FAIL starve_payload[%0d]: out=%h, required nothing queued", k, rout);
            end else begin
                exp_val = exp_q[ridx].pop_front();
                if (rout !== exp_val) begin
                    errors++;
                    $display("FAIL starve_payload[%0d]: out=%h, required %h", k, rout, exp_val);
                end
            end
            tick();
        end
        ack_in = 1'b0;
    endtask

    task automatic test_queue_full();
        int budget;
        do_reset();
        weights = 16'h1111;
        for (int n = 0; n < 5; n++) begin
            push(0, 1'b0);
            tick();
            if (n == 3) begin
                checks++;
                if (ack_out[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL full_three: ack0=%b with 3 queued, required 1", ack_out[0]);
                end
            end
        end
        checks++;
        if (ack_out !== 4'b1110) begin
            errors++;
            $display("FAIL full_ack: ack=%b with ch0 full, required 1110", ack_out);
        end
        ack_in = 1'b1;
        exp_val = exp_q[0].pop_front();
        checks++;
        if (rvld !== 1'b1 || rout !== exp_val) begin
            errors++;
            $display("FAIL full_pop1: valid=%b out=%h, required 1/%h", rvld, rout, exp_val);
        end
        tick();
        checks++;
        if (ack_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_after_pop: ack0=%b, required 1", ack_out[0]);
        end
        exp_val = exp_q[0].pop_front();
        checks++;
        if (rvld !== 1'b1 || rout !== exp_val) begin
            errors++;
            $display("FAIL full_pop2: valid=%b out=%h, required 1/%h", rvld, rout, exp_val);
        end
        push(0, 1'b0);
        tick();
        checks++;
        if (ack_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop: ack0=%b after push+pop at 3, required 1", ack_out[0]);
        end
        ack_in = 1'b0;
        push(0, 1'b0);
        tick();
        checks++;
        if (ack_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_refill: ack0=%b, required 0", ack_out[0]);
        end
        ack_in = 1'b1;
        budget = 0;
        while ((rvld === 1'b1 || exp_q[0].size() != 0) && budget < 20) begin
            if (rvld === 1'b1) begin
                checks++;
                if (exp_q[0].size() == 0 || ridx !== 2'd0) begin
                    errors++;
                    $display("FAIL full_drain: unexpected out=%h idx=%0d, required none", rout, ridx);
                end else begin
                    exp_val = exp_q[0].pop_front();
                    if (rout !== exp_val) begin
                        errors++;
                        $display("FAIL full_drain: out=%h, required %h", rout, exp_val);
                    end
                end
            end
            tick();
            budget++;
        end
        checks++;
        if (budget >= 20 || exp_q[0].size() != 0) begin
            errors++;
            $display("FAIL full_drain_timeout: %0d entries left, required 0", exp_q[0].size());
        end
        ack_in = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        do_reset();
        weights = 16'h1111;
        for (int ch = 0; ch < 4; ch++) push(ch, 1'b0);
        tick();
        for (int ch = 0; ch < 4; ch++) push(ch, 1'b0);
        tick();
        checks++;
        if (rvld !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: valid=%b, required 1", rvld);
        end
        reset_in = 1'b1;
        #1;
        checks++;
        if (ack_out !== 4'h0) begin
            errors++;
            $display("FAIL midrst_ack: ack=%b during reset, required 0000", ack_out);
        end
        tick();
        reset_in = 1'b0;
        clear_model();
        #1;
        checks++;
        if (rvld !== 1'b0 || rout !== 64'h0 || ridx !== 2'd0 || ack_out !== 4'hF) begin
            errors++;
            $display("FAIL midrst_outputs: valid=%b out=%h idx=%0d ack=%b, required 0/0/0/1111", rvld, rout, ridx, ack_out);
        end
        ack_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (rvld !== 1'b0) begin
                errors++;
                $display("FAIL midrst_flushed[%0d]: valid=%b out=%h, required 0", c, rvld, rout);
            end
        end
        for (int ch = 0; ch < 4; ch++) push(ch, 1'b0);
        tick();
        tick();
        exp_idx = '{0, 1, 2, 3};
        for (int k = 0; k < 4; k++) begin
            int e;
            e = exp_idx.pop_front();
            checks++;
            if (rvld !== 1'b1 || int'(ridx) != e) begin
                errors++;
                $display("FAIL midrst_order[%0d]: valid=%b idx=%0d, required 1/%0d", k, rvld, ridx, e);
            end else begin
                exp_val = exp_q[ridx].pop_front();
                if (rout !== exp_val) begin
                    errors++;
                    $display("FAIL midrst_payload[%0d]: out=%h, required %h", k, rout, exp_val);
                end
            end
            tick();
        end
        ack_in = 1'b0;
    endtask

    initial begin
        reset_in = 1'b1;
        req_data = '0;
        req_vld  = '0;
        req_crit = '0;
        weights  = 16'h1111;
        ack_in   = 1'b0;
        test_reset();
        test_single_push();
        test_weighted_rr();
        test_critical_preempt();
        test_stall_starvation();
        test_queue_full();
        test_reset_mid_transfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
